cic_decim_ctrl: RTL
===================

Name: cic_decim_ctrl

Overview:
- Sequencing controller for the CIC decimator of the mic array.
- Generates the decimation strobe that clocks the comb section (the lr_clk role). Sequences the N comb stages one per cycle.
- Captures the per-channel comb results and serializes NCH channels onto one valid/ready stream for downstream processing.
- Sits between the per-channel integrator/comb datapath and the beamforming/output path.

Parameters:
- NCH, 4, number of microphone channels sharing the output stream
- OW, 19, comb output width per channel
- N, 3, number of comb stages to sequence
- RW, 8, width of the runtime decimation ratio
- R_DEFAULT, 16, decimation ratio loaded at reset
- CW, $clog2(NCH) (minimum 1), channel index width

Ports:
- clk  in  1  system clock; one input bit per channel per enabled cycle
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  run decimation counter
- i_ratio  in  RW  requested decimation ratio; applied at next wrap
- i_comb_data  in  NCH*OW  final comb outputs; channel c at bits [c*OW +: OW]
- o_dec_stb  out  1  one-cycle decimation strobe
- o_comb_en  out  N  one-hot comb stage enable; bit k = stage k
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accepts the word
- o_chan  out  CW  channel index of o_data
- o_data  out  OW  channel sample
- o_frame_start  out  1  high with o_valid for channel 0 of a frame
- o_overrun_cnt  out  8  saturating count of dropped frames

Behaviour:
- Reset values:
  - cnt=0, ratio=R_DEFAULT.
  - o_dec_stb=0, o_comb_en=0, o_valid=0.
  - o_chan=0, o_data=0, o_frame_start=0, o_overrun_cnt=0.
  - pending mask=0, FSM=IDLE.
- Ratio: eff = i_ratio clamped to minimum 2. ratio reg loads eff when cnt==ratio-1 and i_enable, or any cycle while i_enable=0.
- Counter:
  - i_enable=1: cnt increments. At cnt==ratio-1 it wraps to 0 and o_dec_stb=1 in the next cycle, exactly one cycle wide.
  - i_enable=0: cnt is forced to 0 and no new strobes are issued.
  - Strobes already issued still complete the sequence and drain.
- Stage sequencing (shift register):
  - o_comb_en[0] = o_dec_stb delayed 1 cycle.
  - o_comb_en[k] = o_comb_en[k-1] delayed 1 cycle.
- Capture: the cycle after o_comb_en[N-1] is a capture cycle. Latency is N+1 clocks from o_dec_stb to capture, with o_valid in the following cycle.
- Output FSM:
  - IDLE, capture: latch all NCH words into the frame buffer, mask=all ones, go to SEND.
  - SEND, data presented: o_valid=1; o_chan = lowest set mask bit; o_data = buffer[o_chan]; o_frame_start = (o_chan==0 && mask all ones).
  - SEND, handshake: o_valid&&i_ready clears that mask bit. If the mask becomes 0, go to IDLE.
  - Stability: o_data/o_chan are held stable while o_valid && !i_ready.
- Overrun: a capture while in SEND, except on the cycle of the final handshake, drops the new frame. The buffer is unchanged and o_overrun_cnt increments, saturating at 255.
- Capture on the final-handshake cycle: the last word completes and the new frame is accepted. The FSM stays in SEND with mask all ones and no overrun.
- No-overrun condition: with i_ready held high there is no overrun when ratio >= NCH+1.
- Reset mid-frame: everything returns to reset values the next cycle and the pending frame is discarded.

Decomposition:
- Shared package cic_pkg:
  - Constants: R_DEFAULT, N, OW, NCH, ratio minimum 2.
  - Enum out_state_t {IDLE, SEND}.
  - Function clamp_ratio.
- One natural sub-module: cic_frame_serializer (buffer, mask, lowest-set-bit select, valid/ready FSM, overrun counter).
- The counter and stage shift register stay in cic_decim_ctrl.

Test Plan:
- Reset release with i_enable=1, R_DEFAULT=16, i_ready=1 -> first o_dec_stb on the 16th enabled cycle. o_comb_en bits 0,1,2 follow in consecutive cycles. o_valid 5 cycles after the strobe. Channels 0..3 on consecutive cycles, o_frame_start only with chan 0.
- i_comb_data = {19'h0DDDD,19'h0CCCC,19'h0BBBB,19'h0AAAA} -> o_data sequence 0AAAA, 0BBBB, 0CCCC, 0DDDD.
- i_ready toggling 1,0,0,1 mid-frame -> o_chan/o_data held through stalls, no word lost or duplicated.
- i_ratio changed 16->8 mid-count -> the current period still lasts 16 and the following strobes are spaced 8. i_ratio=0 or 1 -> spacing 2.
- Ratio 4 with i_ready=0 for 40 cycles -> o_overrun_cnt increments once per dropped strobe. The original frame is still output intact when i_ready rises.
- Assert i_reset during SEND with mask partially cleared -> next cycle o_valid=0 and all counters are 0. With i_enable=1 the first strobe then occurs 16 cycles after reset release.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants, output-state encoding and ratio clamp for the CIC decimator controller.
package cic_pkg;

  localparam int unsigned NCH       = 4;
  localparam int unsigned OW        = 19;
  localparam int unsigned N         = 3;
  localparam int unsigned RW        = 8;
  localparam int unsigned R_DEFAULT = 16;
  localparam int unsigned RATIO_MIN = 2;
  localparam int unsigned CW        = (NCH > 1) ? $clog2(NCH) : 1;

  typedef logic [0:0] out_state_t;
  localparam out_state_t IDLE = 1'b0;
  localparam out_state_t SEND = 1'b1;

  localparam logic [RW-1:0] RATIO_MIN_V = RW'(RATIO_MIN);

  function automatic logic [RW-1:0] clamp_ratio(input logic [RW-1:0] ratio);
    return (ratio < RATIO_MIN_V) ? RATIO_MIN_V : ratio;
  endfunction

endpackage

// File: rtl/cic_frame_serializer.sv
// Captures one frame of NCH comb results and streams it out lowest channel first over
// valid/ready; frames arriving while a frame is still pending are dropped and counted.
module cic_frame_serializer
  import cic_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cap_i,
  input  logic [NCH*OW-1:0]   data_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [CW-1:0]       chan_o,
  output logic [OW-1:0]       data_o,
  output logic                frame_start_o,
  output logic [7:0]          overrun_cnt_o
);

  out_state_t               state_q, state_d;
  logic [NCH-1:0]           mask_q, mask_d;
  logic [NCH-1:0][OW-1:0]   buf_q, buf_d;
  logic [7:0]               ovr_q, ovr_d;

  logic [CW-1:0]            chan;
  logic                     found;
  logic                     valid;
  logic                     hs;
  logic [NCH-1:0]           mask_hs;
  logic                     last_hs;

  always_comb begin
    chan  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (mask_q[i] && !found) begin
        chan  = CW'(i);
        found = 1'b1;
      end
    end
  end

  assign valid   = (state_q == SEND);
  assign hs      = valid && ready_i;
  assign mask_hs = hs ? (mask_q & ~(NCH'(1) << chan)) : mask_q;
  assign last_hs = hs && (mask_hs == '0);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    buf_d   = buf_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (cap_i) begin
          buf_d   = data_i;
          mask_d  = '1;
          state_d = SEND;
        end
      end
      SEND: begin
        // A capture landing on the final handshake hands over seamlessly to the new frame.
        if (cap_i && last_hs) begin
          buf_d  = data_i;
          mask_d = '1;
        end else begin
          mask_d = mask_hs;
          if (cap_i && (ovr_q != 8'hff)) begin
            ovr_d = ovr_q + 8'd1;
          end
          if (mask_hs == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      buf_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      buf_q   <= buf_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid_o       = valid;
  assign chan_o        = chan;
  assign data_o        = valid ? buf_q[chan] : '0;
  assign frame_start_o = valid && (chan == '0) && (&mask_q);
  assign overrun_cnt_o = ovr_q;

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: decimation counter and strobe, one-hot comb stage walk, and
// hand-off of the captured comb outputs to the frame serializer.
module cic_decim_ctrl
  import cic_pkg::*;
(
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [RW-1:0]       i_ratio,
  input  logic [NCH*OW-1:0]   i_comb_data,
  output logic                o_dec_stb,
  output logic [N-1:0]        o_comb_en,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [CW-1:0]       o_chan,
  output logic [OW-1:0]       o_data,
  output logic                o_frame_start,
  output logic [7:0]          o_overrun_cnt
);

  logic [RW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] ratio_q, ratio_d;
  logic          dec_stb_q;
  logic [N-1:0]  comb_en_q;
  logic          cap_q;
  logic          wrap;

  assign wrap = i_enable && (cnt_q == (ratio_q - RW'(1)));

  // New ratios only take effect at a period boundary, or freely while stopped.
  always_comb begin
    cnt_d   = cnt_q + RW'(1);
    ratio_d = ratio_q;
    if (!i_enable || wrap) begin
      cnt_d   = '0;
      ratio_d = clamp_ratio(i_ratio);
    end
  end

  // The stage walk runs regardless of i_enable so issued strobes always drain.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      cnt_q     <= '0;
      ratio_q   <= RW'(R_DEFAULT);
      dec_stb_q <= 1'b0;
      comb_en_q <= '0;
      cap_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      dec_stb_q <= wrap;
      comb_en_q <= (comb_en_q << 1) | N'(dec_stb_q);
      cap_q     <= comb_en_q[N-1];
    end
  end

  assign o_dec_stb = dec_stb_q;
  assign o_comb_en = comb_en_q;

  cic_frame_serializer u_serializer (
    .clk_i         (clk),
    .rst_i         (i_reset),
    .cap_i         (cap_q),
    .data_i        (i_comb_data),
    .ready_i       (i_ready),
    .valid_o       (o_valid),
    .chan_o        (o_chan),
    .data_o        (o_data),
    .frame_start_o (o_frame_start),
    .overrun_cnt_o (o_overrun_cnt)
  );

endmodule
